// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for a 4-bit LFSR state stream with lock/loss detection
module lfsr_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [3:0]       data,
    input  logic             clear,
    output logic             locked,
    output logic [1:0]       fsm_state,
    output logic [3:0]       expected,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] smp_cnt
);
    typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    state_t state;
    logic [MW-1:0] match_ctr;
    logic [LW-1:0] miss_ctr;
    logic hit, last_match, last_miss;
    logic [3:0] nxt_data, nxt_exp;
    logic [CNT_W-1:0] err_inc, smp_inc;
    assign fsm_state  = state;
    assign hit        = data == expected;
    assign nxt_data   = {data[2:0], data[3] ^ data[2]};
    assign nxt_exp    = {expected[2:0], expected[3] ^ expected[2]};
    assign last_match = match_ctr == MW'(LOCK_CNT - 1);
    assign last_miss  = miss_ctr == LW'(LOSS_CNT - 1);
    assign err_inc    = &err_cnt ? err_cnt : err_cnt + CNT_W'(1);
    assign smp_inc    = &smp_cnt ? smp_cnt : smp_cnt + CNT_W'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            locked    <= 1'b0;
            expected  <= 4'b0000;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            smp_cnt   <= '0;
            match_ctr <= '0;
            miss_ctr  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (valid) begin
                case (state)
                    HUNT: if (data != 4'b0000) begin
                        expected  <= nxt_data;
                        match_ctr <= '0;
                        state     <= SYNC;
                    end
                    SYNC: if (hit) begin
                        match_ctr <= match_ctr + MW'(1);
                        expected  <= nxt_exp;
                        if (last_match) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            miss_ctr <= '0;
                        end
                    end else begin
                        match_ctr <= '0;
                        if (data != 4'b0000) expected <= nxt_data;
                        else state <= HUNT;
                    end
                    LOCKED: begin
                        // flywheel: keep predicting even through bad samples
                        expected <= nxt_exp;
                        smp_cnt  <= smp_inc;
                        if (hit) miss_ctr <= '0;
                        else begin
                            err_pulse <= 1'b1;
                            err_cnt   <= err_inc;
                            miss_ctr  <= miss_ctr + LW'(1);
                            if (last_miss) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
            if (clear) begin
                err_cnt <= '0;
                smp_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: scoreboard bench for lfsr_checker, plus a narrow-counter instance for saturation
module tb_lfsr_checker;
    localparam int LOCK = 4;
    localparam int LOSS = 3;
    logic clk = 1'b0;
    logic rst = 1'b1, valid = 1'b0, clear = 1'b0;
    logic [3:0] data = 4'b0000;
    logic locked, err_pulse, locked2, err_pulse2;
    logic [1:0] fsm_state, fsm_state2;
    logic [3:0] expected, expected2;
    logic [15:0] err_cnt, smp_cnt;
    logic [1:0] err_cnt2, smp_cnt2;
    logic [39:0] got, e;
    logic [39:0] sbq[$];
    int n_cmp = 0, n_err = 0;
    logic [1:0] m_st;
    logic [3:0] m_ex;
    logic m_ep;
    logic [15:0] m_ec, m_sc;
    int m_mc, m_mi;

    always #5 clk = ~clk;
    assign got = {locked, fsm_state, expected, err_pulse, err_cnt, smp_cnt};

    lfsr_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .valid(valid), .data(data), .clear(clear),
        .locked(locked), .fsm_state(fsm_state), .expected(expected),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .smp_cnt(smp_cnt));

    lfsr_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .valid(valid), .data(data), .clear(clear),
        .locked(locked2), .fsm_state(fsm_state2), .expected(expected2),
        .err_pulse(err_pulse2), .err_cnt(err_cnt2), .smp_cnt(smp_cnt2));

    function automatic logic [3:0] nxt(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    // drive one cycle, advance the reference model, queue its expected outputs
    task automatic step(input logic r, input logic v, input logic [3:0] d, input logic c);
        rst = r; valid = v; data = d; clear = c;
        if (r) begin
            m_st = 0; m_ex = 0; m_ep = 0; m_ec = 0; m_sc = 0; m_mc = 0; m_mi = 0;
        end else begin
            m_ep = 0;
            if (v) begin
                if (m_st == 0) begin
                    if (d != 0) begin m_ex = nxt(d); m_mc = 0; m_st = 1; end
                end else if (m_st == 1) begin
                    if (d == m_ex) begin
                        m_mc++; m_ex = nxt(m_ex);
                        if (m_mc == LOCK) begin m_st = 2; m_mi = 0; end
                    end else begin
                        m_mc = 0;
                        if (d != 0) m_ex = nxt(d); else m_st = 0;
                    end
                end else begin
                    if (m_sc != 16'hFFFF) m_sc++;
                    if (d != m_ex) begin
                        m_ep = 1; m_mi++;
                        if (m_ec != 16'hFFFF) m_ec++;
                        if (m_mi == LOSS) m_st = 0;
                    end else m_mi = 0;
                    m_ex = nxt(m_ex);
                end
            end
            if (c) begin m_ec = 0; m_sc = 0; end
        end
        sbq.push_back({m_st == 2, m_st, m_ex, m_ep, m_ec, m_sc});
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 4'h0, 0);
            e = sbq.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL reset[%0d]: got %h expected %h", i, got, e); end
        end
        n_cmp++;
        if (got !== 40'h0) begin n_err++; $display("FAIL reset_values: got %h expected 0", got); end
    endtask

    task automatic do_lock(input string tag);
        logic [3:0] s [5] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
        for (int i = 0; i < 5; i++) begin
            step(0, 1, s[i], 0);
            e = sbq.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL %s[%0d]: got %h expected %h", tag, i, got, e); end
        end
    endtask

    task automatic test_lock();
        do_lock("lock");
        n_cmp++;
        if ({locked, fsm_state, expected, err_cnt} !== {1'b1, 2'd2, 4'h2, 16'h0}) begin
            n_err++; $display("FAIL lock_state: got %b/%0d/%h/%0d expected 1/2/2/0", locked, fsm_state, expected, err_cnt);
        end
    endtask

    task automatic test_single_error();
        logic [3:0] s [3] = '{4'h3, 4'h4, 4'h9};
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, s[i], 0);
            pulses += int'(err_pulse);
            e = sbq.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL single_err[%0d]: got %h expected %h", i, got, e); end
        end
        n_cmp++;
        if ({pulses, locked, err_cnt, smp_cnt} !== {32'd1, 1'b1, 16'd1, 16'd3}) begin
            n_err++; $display("FAIL single_err_sum: got p%0d l%b e%0d s%0d expected p1 l1 e1 s3", pulses, locked, err_cnt, smp_cnt);
        end
    endtask

    task automatic test_loss();
        logic [3:0] d = 4'h7;
        step(0, 0, 4'h0, 1);
        e = sbq.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL loss_clear: got %h expected %h", got, e); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, ~m_ex, 0);
            e = sbq.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL loss[%0d]: got %h expected %h", i, got, e); end
        end
        n_cmp++;
        if ({err_cnt, locked, fsm_state, err_pulse} !== {16'd3, 1'b0, 2'd0, 1'b1}) begin
            n_err++; $display("FAIL loss_state: got e%0d l%b st%0d p%b expected e3 l0 st0 p1", err_cnt, locked, fsm_state, err_pulse);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, d, 0);
            d = nxt(d);
            e = sbq.pop_front(); n_cmp++;
            if (got !== e || locked !== (i == 4)) begin
                n_err++; $display("FAIL relock[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_zero_gaps();
        step(1, 0, 4'h0, 0);
        void'(sbq.pop_front());
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 4'h0, 0);
            e = sbq.pop_front(); n_cmp++;
            if (got !== e || fsm_state !== 2'd0) begin n_err++; $display("FAIL zero_hunt[%0d]: got %h expected %h", i, got, e); end
        end
        do_lock("gap_lock");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'($urandom), 0);
            e = sbq.pop_front(); n_cmp++;
            if (got !== e || expected !== 4'h2 || err_pulse !== 1'b0) begin
                n_err++; $display("FAIL gap[%0d]: got %h expected %h", i, got, e);
            end
        end
        step(0, 1, 4'h2, 0);
        e = sbq.pop_front(); n_cmp++;
        if (got !== e || err_cnt !== 16'd0 || smp_cnt !== 16'd1) begin n_err++; $display("FAIL gap_resume: got %h expected %h", got, e); end
    endtask

    task automatic test_clear_collision();
        logic [3:0] s [3] = '{4'hF, 4'hE, 4'h5};
        step(0, 1, ~m_ex, 1);
        e = sbq.pop_front(); n_cmp++;
        if (got !== e || err_cnt !== 16'd0 || err_pulse !== 1'b1) begin n_err++; $display("FAIL clear_collide: got %h expected %h", got, e); end
        step(1, 0, 4'h0, 0);
        void'(sbq.pop_front());
        for (int i = 0; i < 3; i++) begin
            step(0, 1, s[i], 0);
            e = sbq.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL reseed[%0d]: got %h expected %h", i, got, e); end
        end
        n_cmp++;
        if ({expected, fsm_state} !== {4'hB, 2'd1}) begin
            n_err++; $display("FAIL reseed_state: got %h/%0d expected b/1", expected, fsm_state);
        end
    endtask

    task automatic test_reset_sat();
        do_lock("sat_lock");
        step(1, 1, m_ex, 0);
        e = sbq.pop_front(); n_cmp++;
        if (got !== e || got !== 40'h0) begin n_err++; $display("FAIL mid_reset: got %h expected 0", got); end
        do_lock("sat_relock");
        for (int i = 0; i < 8; i++) begin
            step(0, 1, i[0] ? m_ex : ~m_ex, 0);
            e = sbq.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL sat[%0d]: got %h expected %h", i, got, e); end
        end
        n_cmp++;
        if ({err_cnt2, smp_cnt2, locked2, err_cnt} !== {2'd3, 2'd3, 1'b1, 16'd4}) begin
            n_err++; $display("FAIL saturate: got e2=%0d s2=%0d l2=%b e=%0d expected 3/3/1/4", err_cnt2, smp_cnt2, locked2, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_loss();
        test_zero_gaps();
        test_clear_collision();
        test_reset_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
